lisp_io_bridge: RTL and testbench

LISP_IO_BRIDGE -- requirements
Module: lisp_io_bridge

---
 rtl/lisp_io_bridge.sv | 153 +++++++++++++++
 tb/tb_lisp_io_bridge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lisp_io_bridge.sv
// Core-to-memory/peripheral bridge: plain memory traffic passes straight through,
// while the top address page is decoded into stalled, timeout-guarded register accesses.
module lisp_io_bridge #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 19,
  parameter int REG_WIDTH    = 16,
  parameter int CHAN_BITS    = 2,
  parameter int NUM_CHANNELS = 4,
  parameter int INDEX_BITS   = 5,
  parameter int TIMEOUT      = 15
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [ADDR_WIDTH-1:0]            core_address,
  input  logic [DATA_WIDTH-1:0]            core_write_value,
  input  logic                             core_write_enable,
  output logic [DATA_WIDTH-1:0]            core_read_value,
  output logic                             core_stall,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_write_value,
  output logic                             mem_write_enable,
  input  logic [DATA_WIDTH-1:0]            mem_read_value,
  output logic [NUM_CHANNELS-1:0]          periph_sel,
  output logic [INDEX_BITS-1:0]            periph_index,
  output logic                             periph_read,
  output logic                             periph_write,
  output logic [REG_WIDTH-1:0]             periph_write_value,
  input  logic [NUM_CHANNELS*REG_WIDTH-1:0] periph_read_value,
  input  logic [NUM_CHANNELS-1:0]          periph_ready,
  output logic                             timeout_error
);

  localparam int IO_BITS = CHAN_BITS + INDEX_BITS;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    io_hit, mapped, ready_sel, expired;
  logic [CHAN_BITS-1:0]    chan;
  logic [INDEX_BITS-1:0]   index;
  logic [NUM_CHANNELS-1:0] chan_onehot;
  logic [REG_WIDTH-1:0]    chan_value [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    sel_value;

  logic [NUM_CHANNELS-1:0] sel_reg;
  logic [INDEX_BITS-1:0]   index_reg;
  logic                    read_reg, write_reg, timeout_reg;
  logic [REG_WIDTH-1:0]    wdata_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [DATA_WIDTH-1:0]   capture_reg;

  assign io_hit = &core_address[ADDR_WIDTH-1:IO_BITS];
  assign chan   = core_address[INDEX_BITS +: CHAN_BITS];
  assign index  = core_address[INDEX_BITS-1:0];
  assign mapped = ({1'b0, chan} < (CHAN_BITS+1)'(NUM_CHANNELS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign chan_onehot[gi] = (chan == CHAN_BITS'(gi));
      assign chan_value[gi]  = periph_read_value[gi*REG_WIDTH +: REG_WIDTH];
    end
  endgenerate

  // sel_reg is one-hot while waiting, so masking also discards other channels' ready
  always_comb begin
    sel_value = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sel_reg[c]) sel_value = sel_value | chan_value[c];
    end
  end

  assign ready_sel = |(periph_ready & sel_reg);
  assign expired   = (count_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    core_stall = 1'b0;
    case (state_reg)
      IDLE: begin
        core_stall = io_hit;
        if (io_hit) state_next = mapped ? WAIT : DONE;
      end
      WAIT: begin
        core_stall = 1'b1;
        if (ready_sel || expired) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_reg     <= '0;
      index_reg   <= '0;
      read_reg    <= 1'b0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      count_reg   <= '0;
      capture_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io_hit && mapped) begin
            sel_reg   <= chan_onehot;
            index_reg <= index;
            read_reg  <= !core_write_enable;
            write_reg <= core_write_enable;
            wdata_reg <= core_write_value[REG_WIDTH-1:0];
            count_reg <= '0;
          end else if (io_hit) begin
            capture_reg <= '0;
          end
        end
        WAIT: begin
          // A ready arriving on the final allowed cycle wins over the timeout
          if (ready_sel || expired) begin
            if (ready_sel) capture_reg <= read_reg ? DATA_WIDTH'(sel_value) : '0;
            else           capture_reg <= DATA_WIDTH'({REG_WIDTH{1'b1}});
            if (!ready_sel) timeout_reg <= 1'b1;
            sel_reg   <= '0;
            index_reg <= '0;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_address        = core_address;
  assign mem_write_value    = core_write_value;
  assign mem_write_enable   = core_write_enable && !io_hit;
  assign core_read_value    = (state_reg == DONE) ? capture_reg : mem_read_value;
  assign periph_sel         = sel_reg;
  assign periph_index       = index_reg;
  assign periph_read        = read_reg;
  assign periph_write       = write_reg;
  assign periph_write_value = wdata_reg;
  assign timeout_error      = timeout_reg;

endmodule

// File: tb/tb_lisp_io_bridge.sv
// Self-checking bench for lisp_io_bridge: directed vector table, randomized accesses
// against a transaction-level model, unmapped-channel and mid-access reset sequences.
module tb_lisp_io_bridge;
  localparam int AW = 16, DW = 19, RW = 16, CB = 2, NC = 4, IB = 5, TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] core_address;
  logic [DW-1:0] core_write_value;
  logic          core_write_enable;
  logic [DW-1:0] core_read_value;
  logic          core_stall;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_value;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_value = '0;
  logic [NC-1:0] periph_sel;
  logic [IB-1:0] periph_index;
  logic          periph_read, periph_write;
  logic [RW-1:0] periph_write_value;
  logic [NC*RW-1:0] periph_read_value;
  logic [NC-1:0] periph_ready;
  logic          timeout_error;

  // second instance with three channels, used only for the unmapped-channel case
  logic [AW-1:0] core_address_3;
  logic [DW-1:0] core_read_value_3;
  logic          core_stall_3;
  logic [AW-1:0] mem_address_3;
  logic [DW-1:0] mem_write_value_3;
  logic          mem_write_enable_3;
  logic [2:0]    periph_sel_3;
  logic [IB-1:0] periph_index_3;
  logic          periph_read_3, periph_write_3;
  logic [RW-1:0] periph_write_value_3;
  logic          timeout_error_3;

  lisp_io_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW), .CHAN_BITS(CB),
                   .NUM_CHANNELS(NC), .INDEX_BITS(IB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_address(core_address), .core_write_value(core_write_value),
    .core_write_enable(core_write_enable), .core_read_value(core_read_value),
    .core_stall(core_stall),
    .mem_address(mem_address), .mem_write_value(mem_write_value),
    .mem_write_enable(mem_write_enable), .mem_read_value(mem_read_value),
    .periph_sel(periph_sel), .periph_index(periph_index), .periph_read(periph_read),
    .periph_write(periph_write), .periph_write_value(periph_write_value),
    .periph_read_value(periph_read_value), .periph_ready(periph_ready),
    .timeout_error(timeout_error));

  lisp_io_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW), .CHAN_BITS(CB),
                   .NUM_CHANNELS(3), .INDEX_BITS(IB), .TIMEOUT(TO)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .core_address(core_address_3), .core_write_value(19'h0),
    .core_write_enable(1'b0), .core_read_value(core_read_value_3),
    .core_stall(core_stall_3),
    .mem_address(mem_address_3), .mem_write_value(mem_write_value_3),
    .mem_write_enable(mem_write_enable_3), .mem_read_value(19'h5A5A5),
    .periph_sel(periph_sel_3), .periph_index(periph_index_3), .periph_read(periph_read_3),
    .periph_write(periph_write_3), .periph_write_value(periph_write_value_3),
    .periph_read_value(48'h0), .periph_ready(3'b000),
    .timeout_error(timeout_error_3));

  // one-cycle-latency memory behind the core port
  logic [DW-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
      mem_read_value <= '0;
    end else begin
      if (mem_write_enable) tb_mem[mem_address[7:0]] <= mem_write_value;
      mem_read_value <= tb_mem[mem_address[7:0]];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: stall length, returned data and sticky error
  bit            ref_to;
  logic [DW-1:0] ref_mem [int];

  function automatic void model(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                                input int lat, input logic [RW-1:0] rval,
                                output int stall, output logic [DW-1:0] rv);
    if (&addr[15:7]) begin
      if (lat < TO) begin
        stall = lat + 2;
        rv = we ? 19'h0 : {3'b000, rval};
      end else begin
        stall = TO + 1;
        rv = 19'h0FFFF;
        ref_to = 1'b1;
      end
    end else begin
      stall = 0;
      rv = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 19'h0;
      if (we) ref_mem[int'(addr)] = wdata;
    end
  endfunction

  task automatic access(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                        input int lat, input logic [RW-1:0] rval,
                        input int exp_stall, input logic [DW-1:0] exp_rv, input bit exp_to,
                        input string tag);
    bit hit = &addr[15:7];
    int ch = int'(addr[6:5]);
    int n = 0;
    int stalls = 0;
    int strobes = 0;
    bit done = 0;
    logic [DW-1:0] rv_seen = '0;
    logic [NC-1:0] rdy;
    @(posedge clk); #1;
    core_address = addr;
    core_write_enable = we;
    core_write_value = wdata;
    for (int c = 0; c < NC; c++) periph_read_value[c*RW +: RW] = (c == ch) ? rval : RW'($urandom);
    while (!done && n < 40) begin
      rdy = NC'($urandom);
      rdy[ch] = (n >= 1 && n - 1 == lat);
      periph_ready = rdy;
      @(negedge clk);
      if (n == 0) begin
        chk({tag, "_mem_we"}, 32'(mem_write_enable), 32'(we && !hit));
        chk({tag, "_mem_pass"}, {mem_address, 16'(mem_write_value)}, {addr, 16'(wdata)});
      end
      if (!core_stall) begin
        done = 1;
        rv_seen = core_read_value;
        chk({tag, "_idle_strobes"}, {periph_sel, periph_index, periph_read, periph_write}, 32'h0);
      end else begin
        stalls++;
        if (n >= 1) begin
          if (periph_read || periph_write) strobes++;
          chk({tag, "_wait_bus"},
              {periph_sel, periph_index, periph_read, periph_write, periph_write_value},
              {NC'(1 << ch), addr[4:0], !we, we, wdata[15:0]});
        end
        @(posedge clk); #1;
        n++;
      end
    end
    chk({tag, "_cycle_bound"}, 32'(done), 32'h1);
    chk({tag, "_stall_cycles"}, stalls, exp_stall);
    chk({tag, "_strobe_cycles"}, strobes, hit ? exp_stall - 1 : 0);
    if (hit) chk({tag, "_io_data"}, 32'(rv_seen), 32'(exp_rv));
    chk({tag, "_timeout_flag"}, 32'(timeout_error), 32'(exp_to));
    @(posedge clk); #1;
    core_address = '0;
    core_write_enable = 1'b0;
    periph_ready = '0;
    if (!hit) begin
      @(negedge clk);
      chk({tag, "_mem_data"}, 32'(core_read_value), 32'(exp_rv));
    end
    $display("txn %s addr=%h we=%0d lat=%0d stall=%0d data=%h", tag, addr, we, lat, stalls,
             hit ? rv_seen : core_read_value);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            lat;
    logic [RW-1:0] rval;
    int            stall;
    logic [DW-1:0] rv;
    bit            to;
  } vec_t;

  vec_t vt [7];

  initial begin
    int s;
    logic [DW-1:0] r;
    vt[0] = '{16'h0010, 1'b1, 19'h12345, 0,  16'h0000, 0,  19'h00000, 1'b0};
    vt[1] = '{16'h0010, 1'b0, 19'h00000, 0,  16'h0000, 0,  19'h12345, 1'b0};
    vt[2] = '{16'hFF85, 1'b0, 19'h00000, 2,  16'hBEEF, 4,  19'h0BEEF, 1'b0};
    vt[3] = '{16'hFFC1, 1'b1, 19'h7ABCD, 0,  16'h1111, 2,  19'h00000, 1'b0};
    vt[4] = '{16'hFFFF, 1'b0, 19'h00000, 14, 16'h8001, 16, 19'h08001, 1'b0};
    vt[5] = '{16'hFFA3, 1'b0, 19'h00000, 99, 16'h1234, 16, 19'h0FFFF, 1'b1};
    vt[6] = '{16'h0010, 1'b0, 19'h00000, 0,  16'h0000, 0,  19'h12345, 1'b1};

    reset_n = 1'b0;
    core_address = '0;
    core_address_3 = '0;
    core_write_value = '0;
    core_write_enable = 1'b0;
    periph_read_value = '0;
    periph_ready = '0;
    ref_to = 1'b0;
    #2;
    chk("reset_outputs", {core_stall, periph_sel, periph_index, periph_read, periph_write, timeout_error},
        32'h0);
    @(posedge clk); @(posedge clk); #2;
    chk("reset_read_path", 32'(core_read_value), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      model(vt[i].addr, vt[i].we, vt[i].wdata, vt[i].lat, vt[i].rval, s, r);
      access(vt[i].addr, vt[i].we, vt[i].wdata, vt[i].lat, vt[i].rval,
             vt[i].stall, vt[i].rv, vt[i].to, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic we;
      logic [DW-1:0] wd;
      int lat;
      logic [RW-1:0] rv16;
      int kind = int'($urandom_range(0, 3));
      wd = DW'($urandom);
      rv16 = RW'($urandom);
      lat = int'($urandom_range(0, TO + 2));
      if (kind < 2) begin
        a = AW'($urandom_range(0, 15));
        we = (kind == 0);
      end else begin
        a = {9'h1FF, 2'($urandom), 5'($urandom)};
        we = 1'($urandom);
      end
      model(a, we, wd, lat, rv16, s, r);
      access(a, we, wd, lat, rv16, s, r, ref_to, $sformatf("rnd%0d", i));
    end

    @(posedge clk); #1;
    core_address_3 = 16'hFFE0;
    @(negedge clk);
    chk("unmapped_stall", 32'(core_stall_3), 32'h1);
    chk("unmapped_strobes", {periph_sel_3, periph_read_3, periph_write_3}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("unmapped_done_stall", 32'(core_stall_3), 32'h0);
    chk("unmapped_data", 32'(core_read_value_3), 32'h0);
    @(posedge clk); #1;
    core_address_3 = '0;
    $display("txn unmapped addr=ffe0 data=%h", core_read_value_3);

    @(posedge clk); #1;
    core_address = 16'hFFA0;
    core_write_enable = 1'b0;
    periph_ready = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("prereset_read", 32'(periph_read), 32'h1);
    chk("prereset_timeout", 32'(timeout_error), 32'h1);
    reset_n = 1'b0;
    core_address = '0;
    #1;
    chk("midwait_reset", {periph_sel, periph_read, periph_write, core_stall, timeout_error}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ref_to = 1'b0;
    ref_mem.delete();
    @(negedge clk);
    chk("post_reset_idle", {periph_sel, periph_read, core_stall}, 32'h0);
    $display("txn reset_mid_wait timeout_error=%0d", timeout_error);

    model(16'hFFE7, 1'b0, 19'h0, 1, 16'hC0DE, s, r);
    access(16'hFFE7, 1'b0, 19'h0, 1, 16'hC0DE, s, r, ref_to, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
